// File: rtl/pf_pixel_fifo.sv
// Elastic pixel FIFO that aligns a renderer pixel stream to the timing generator's frame strobe.
// Optional stats (underflow, resync_count, low-water mark) are enabled by PF_PIXEL_FIFO_STATS_EN.
module pf_pixel_fifo #(
   parameter int          DEPTH    = 512,
   parameter logic [23:0] FILL_RGB = 24'h001030
) (
   input  logic        clk_core_12288,
   input  logic        reset_n,
   input  logic [23:0] in_rgb,
   input  logic        in_sof,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        vid_vs,
   input  logic        pix_req,
   output logic [23:0] out_rgb,
   output logic        locked,
   output logic        underflow,
   output logic [7:0]  resync_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {RESYNC, PRIME, RUN} state_t;

   state_t        state;
   state_t        state_next;
   logic [24:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [24:0]   head;
   logic          push;
   logic          pop;
   logic          store;
   logic          frame_ok;
   logic          flush;

   assign head     = mem[rd_ptr];
   assign in_ready = (state == RESYNC) || (count != FULL);
   assign push     = in_valid && in_ready;
   assign pop      = (state == RUN) && pix_req && (count != '0);
   assign frame_ok = (count != '0) && head[24];
   assign flush    = (state == RUN) && vid_vs && !frame_ok;
   // While resyncing only the start-of-frame word is kept; everything else is dropped.
   assign store    = push && !flush && ((state != RESYNC) || in_sof);
   assign locked   = (state == RUN);

   always_comb begin
      state_next = state;
      case (state)
         RESYNC: if (push && in_sof) state_next = PRIME;
         PRIME:  if (vid_vs) state_next = RUN;
         RUN:    if (flush) state_next = RESYNC;
         default: state_next = RESYNC;
      endcase
   end

   always_ff @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESYNC;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_core_12288) begin
      if (store) begin
         mem[wr_ptr] <= {in_sof, in_rgb};
      end
   end

   always_ff @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (store) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({store, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Every request gets an answer; anything but a real pop answers with the fill colour.
   always_ff @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         out_rgb <= '0;
      end else if (pix_req) begin
         out_rgb <= pop ? head[23:0] : FILL_RGB;
      end
   end

`ifdef PF_PIXEL_FIFO_STATS_EN
   logic [7:0]  resync_q;
   logic        underflow_q;
   logic [AW:0] low_water;

   always_ff @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         resync_q    <= '0;
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= (state == RUN) && pix_req && (count == '0);
         if (flush && (resync_q != 8'hFF)) resync_q <= resync_q + 8'd1;
      end
   end

   // Debug-only minimum occupancy seen in RUN, restarted at each frame strobe.
   always_ff @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         low_water <= FULL;
      end else if (state == RUN) begin
         if (vid_vs)                 low_water <= count;
         else if (count < low_water) low_water <= count;
      end
   end

   assign underflow    = underflow_q;
   assign resync_count = resync_q;
`else
   assign underflow    = 1'b0;
   assign resync_count = 8'd0;
`endif

endmodule

// File: tb/tb_pf_pixel_fifo.sv
// Self-checking bench for pf_pixel_fifo: queue-based frame model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pf_pixel_fifo;

   localparam int          DEPTH = 8;
   localparam logic [23:0] FILL  = 24'h001030;
`ifdef PF_PIXEL_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk_core_12288;
   logic        reset_n;
   logic [23:0] in_rgb;
   logic        in_sof;
   logic        in_valid;
   logic        in_ready;
   logic        vid_vs;
   logic        pix_req;
   logic [23:0] out_rgb;
   logic        locked;
   logic        underflow;
   logic [7:0]  resync_count;

   int errors = 0;
   int checks = 0;

   pf_pixel_fifo #(.DEPTH(DEPTH), .FILL_RGB(FILL)) dut (
      .clk_core_12288(clk_core_12288),
      .reset_n(reset_n),
      .in_rgb(in_rgb),
      .in_sof(in_sof),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .vid_vs(vid_vs),
      .pix_req(pix_req),
      .out_rgb(out_rgb),
      .locked(locked),
      .underflow(underflow),
      .resync_count(resync_count)
   );

   initial clk_core_12288 = 1'b0;
   always #5 clk_core_12288 = ~clk_core_12288;

   // Frame-level model: mode 0 = hunting for sof, 1 = primed, 2 = running.
   logic [24:0] q[$];
   int          mode;
   logic [23:0] exp_rgb;
   bit          exp_uf;
   int          exp_rc;
   bit          m_acc;
   bit          m_pop;
   logic [24:0] m_head;

   always @(posedge clk_core_12288 or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         mode    = 0;
         exp_rgb = 24'h0;
         exp_uf  = 1'b0;
         exp_rc  = 0;
      end else begin
         m_acc  = in_valid && (mode == 0 || q.size() < DEPTH);
         m_pop  = (mode == 2) && pix_req && (q.size() > 0);
         m_head = (q.size() > 0) ? q[0] : 25'h0;
         exp_uf = (mode == 2) && pix_req && (q.size() == 0);
         if (pix_req) exp_rgb = m_pop ? m_head[23:0] : FILL;
         if (mode == 2 && vid_vs && !(q.size() > 0 && m_head[24])) begin
            q.delete();
            mode = 0;
            if (exp_rc < 255) exp_rc = exp_rc + 1;
         end else begin
            if (m_pop) void'(q.pop_front());
            if (mode == 0) begin
               if (m_acc && in_sof) begin
                  q.push_back({in_sof, in_rgb});
                  mode = 1;
               end
            end else begin
               if (m_acc) q.push_back({in_sof, in_rgb});
               if (mode == 1 && vid_vs) mode = 2;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk_core_12288) begin
      if (reset_n) begin
         checkOutput("cyc_out_rgb", {8'h0, out_rgb}, {8'h0, exp_rgb});
         checkOutput("cyc_locked", {31'h0, locked}, (mode == 2) ? 32'd1 : 32'd0);
         checkOutput("cyc_in_ready", {31'h0, in_ready}, (mode == 0 || q.size() != DEPTH) ? 32'd1 : 32'd0);
         checkOutput("cyc_underflow", {31'h0, underflow}, (STATS && exp_uf) ? 32'd1 : 32'd0);
         checkOutput("cyc_resync_count", {24'h0, resync_count}, STATS ? exp_rc : 0);
      end
   end

   task automatic applyStimulus(input bit v, input bit s, input logic [23:0] rgb, input bit vs, input bit req);
      @(negedge clk_core_12288);
      in_valid = v;
      in_sof   = s;
      in_rgb   = rgb;
      vid_vs   = vs;
      pix_req  = req;
   endtask

   task automatic settle();
      @(posedge clk_core_12288);
      #1;
   endtask

   initial begin
      reset_n  = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_rgb   = 24'h0;
      vid_vs   = 1'b0;
      pix_req  = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
      checkOutput("rst_out_rgb", {8'h0, out_rgb}, 32'h0);
      checkOutput("rst_locked", {31'h0, locked}, 32'd0);
      checkOutput("rst_resync", {24'h0, resync_count}, 32'd0);
      @(negedge clk_core_12288);
      @(negedge clk_core_12288);
      reset_n = 1'b1;

      // Basic lock: four words, frame strobe, four requests.
      applyStimulus(1, 1, 24'hA00001, 0, 0);
      for (int i = 2; i <= 4; i++) applyStimulus(1, 0, 24'hA00000 + 24'(i), 0, 0);
      applyStimulus(0, 0, 24'h0, 1, 0);
      settle();
      checkOutput("t1_locked", {31'h0, locked}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 0, 24'h0, 0, 1);
         settle();
         checkOutput("t1_pixel", {8'h0, out_rgb}, 32'hA00000 + i);
      end

      // Empty FIFO in RUN: fill colour with an underflow strobe.
      applyStimulus(0, 0, 24'h0, 0, 1);
      settle();
      checkOutput("uf_rgb", {8'h0, out_rgb}, 32'h001030);
      checkOutput("uf_strobe", {31'h0, underflow}, STATS ? 32'd1 : 32'd0);
      applyStimulus(0, 0, 24'h0, 0, 0);
      settle();
      checkOutput("uf_one_cycle", {31'h0, underflow}, 32'd0);
      checkOutput("uf_hold_rgb", {8'h0, out_rgb}, 32'h001030);

      // Frame strobe with an empty head forces a resync.
      applyStimulus(0, 0, 24'h0, 1, 0);
      settle();
      checkOutput("empty_vs_locked", {31'h0, locked}, 32'd0);
      checkOutput("empty_vs_resync", {24'h0, resync_count}, STATS ? 32'd1 : 32'd0);

      // Leading non-sof words are dropped while resyncing.
      for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 24'h000110 + 24'(i), 0, 0);
      applyStimulus(1, 1, 24'h112233, 0, 0);
      applyStimulus(1, 0, 24'h112234, 0, 0);
      applyStimulus(0, 0, 24'h0, 1, 0);
      applyStimulus(0, 0, 24'h0, 0, 1);
      settle();
      checkOutput("t2_first", {8'h0, out_rgb}, 32'h112233);

      // Fill to DEPTH, then a pop frees exactly one slot for the held word.
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 24'hB00000 + 24'(i), 0, 0);
      applyStimulus(1, 0, 24'hC0FFEE, 0, 0);
      settle();
      checkOutput("full_ready", {31'h0, in_ready}, 32'd0);
      applyStimulus(1, 0, 24'hC0FFEE, 0, 1);
      settle();
      checkOutput("full_pop_rgb", {8'h0, out_rgb}, 32'h112234);
      checkOutput("full_pop_ready", {31'h0, in_ready}, 32'd1);
      applyStimulus(1, 0, 24'hC0FFEE, 0, 0);
      settle();
      checkOutput("full_refill_ready", {31'h0, in_ready}, 32'd0);

      // Non-sof head at the frame strobe: flush and count.
      applyStimulus(0, 0, 24'h0, 1, 0);
      settle();
      checkOutput("mis_locked", {31'h0, locked}, 32'd0);
      checkOutput("mis_ready", {31'h0, in_ready}, 32'd1);
      checkOutput("mis_resync", {24'h0, resync_count}, STATS ? 32'd2 : 32'd0);

      // 300 more misalignments saturate the counter.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1, 1, 24'hD00000 + 24'(i), 0, 0);
         applyStimulus(0, 0, 24'h0, 1, 0);
         applyStimulus(0, 0, 24'h0, 0, 1);
         applyStimulus(0, 0, 24'h0, 1, 0);
      end
      settle();
      checkOutput("sat_resync", {24'h0, resync_count}, STATS ? 32'd255 : 32'd0);

      // Mid-frame asynchronous reset with a half-full FIFO, then relock.
      applyStimulus(1, 1, 24'hE00001, 0, 0);
      for (int i = 2; i <= 4; i++) applyStimulus(1, 0, 24'hE00000 + 24'(i), 0, 0);
      applyStimulus(0, 0, 24'h0, 1, 0);
      applyStimulus(0, 0, 24'h0, 0, 1);
      applyStimulus(0, 0, 24'h0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst_out_rgb", {8'h0, out_rgb}, 32'h0);
      checkOutput("arst_locked", {31'h0, locked}, 32'd0);
      checkOutput("arst_resync", {24'h0, resync_count}, 32'd0);
      checkOutput("arst_ready", {31'h0, in_ready}, 32'd1);
      @(negedge clk_core_12288);
      reset_n = 1'b1;
      applyStimulus(1, 1, 24'hF00001, 0, 0);
      applyStimulus(1, 0, 24'hF00002, 0, 0);
      applyStimulus(0, 0, 24'h0, 1, 0);
      applyStimulus(0, 0, 24'h0, 0, 1);
      settle();
      checkOutput("relock_p1", {8'h0, out_rgb}, 32'hF00001);
      checkOutput("relock_locked", {31'h0, locked}, 32'd1);
      applyStimulus(0, 0, 24'h0, 0, 1);
      settle();
      checkOutput("relock_p2", {8'h0, out_rgb}, 32'hF00002);
      applyStimulus(0, 0, 24'h0, 0, 0);
      @(negedge clk_core_12288);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pf_pixel_fifo.md
# pf_pixel_fifo

Elastic pixel buffer between the frame renderer and the video timing generator. It accepts a valid/ready pixel stream with a start-of-frame marker, aligns that stream to the generator's vertical sync, and returns one RGB pixel per generator request. Underflow and misalignment are detected and recovered from without stalling video timing.

## Interface
Parameters:
- DEPTH, 512, FIFO entries; power of two, minimum 4
- FILL_RGB, 24'h001030, colour returned on underflow or when not locked

Ports:
- clk_core_12288  in  1  pixel clock; sole clock domain. Already decided.
- reset_n  in  1  asynchronous, active-low reset. Already decided.
- in_rgb  in  24  renderer pixel, {R,G,B}
- in_sof  in  1  marks the first pixel of a frame
- in_valid  in  1  renderer word present
- in_ready  out  1  block accepts the word this cycle
- vid_vs  in  1  one-cycle frame strobe from the timing generator
- pix_req  in  1  generator needs a pixel; one per active pixel
- out_rgb  out  24  pixel answering the previous cycle's pix_req
- locked  out  1  state is RUN
- underflow  out  1  one-cycle strobe: a pix_req found the FIFO empty while in RUN
- resync_count  out  8  saturating count of frame misalignments

## Operation
- Storage: DEPTH x 25 bits {sof, rgb}. Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push when in_valid && in_ready. Pop only in RUN on pix_req with occupancy > 0.
- in_ready = (occupancy != DEPTH) in PRIME/RUN; 1 in RESYNC. It is derived combinationally from registered state only and never depends on in_valid.
- States:
  - RESYNC (reset state): non-sof words are accepted and discarded. A word with in_sof is pushed, then the state moves to PRIME.
  - PRIME: pushes proceed normally. pix_req returns FILL_RGB without popping. The state moves to RUN on vid_vs.
  - RUN: each pix_req pops the head word onto out_rgb. If the FIFO is empty, the response is FILL_RGB and underflow pulses.
- Frame check in RUN on vid_vs: the head word must be present with sof=1.
  - If so, remain in RUN.
  - Otherwise, flush (occupancy := 0), go to RESYNC, and increment resync_count, saturating at 255.
  - A push in the same cycle as the flush is discarded.
- Simultaneous push and pop: occupancy unchanged. A push into an empty FIFO during a pop cycle does not satisfy that pop (underflow still signalled).
- Read/write pointers wrap modulo DEPTH.

## Timing
- out_rgb is registered. Response appears the cycle after pix_req and holds until the next pix_req.
- underflow is asserted in the same cycle out_rgb shows the fill caused by the empty pop.
- First-pixel latency: a word pushed in cycle N is poppable from cycle N+1.
- Reset values: out_rgb=0, locked=0, underflow=0, resync_count=0, occupancy=0, state=RESYNC. in_ready=1 during and after reset.
- Reset assertion mid-frame clears all state immediately (asynchronous). Deassertion is synchronous to clk_core_12288.
- vid_vs and pix_req in the same cycle: the frame check uses the head before that cycle's pop.

## Configuration
- PF_PIXEL_FIFO_STATS_EN defined:
  - resync_count and underflow operate as specified.
  - An additional internal low-water mark (minimum occupancy seen in RUN since the last vid_vs) is kept for debug probing.
- PF_PIXEL_FIFO_STATS_EN undefined:
  - underflow and resync_count are tied to 0 and the watermark logic is absent.
  - FIFO, state machine and fill behaviour are unchanged.

## Test plan
- Reset, then push 4 words with sof on the first, pulse vid_vs, then issue 4 pix_req: locked=1, and out_rgb returns those 4 words in order, each one cycle after its pix_req.
- Push 3 non-sof words, then a sof word 0x112233 → the first 3 are discarded; after vid_vs, the first pix_req returns 0x112233.
- In RUN with an empty FIFO, pix_req → out_rgb=0x001030 and underflow=1 for one cycle; occupancy stays 0.
- Fill to DEPTH → in_ready=0. Issue one pix_req with in_valid held → occupancy returns to DEPTH, and the held word is accepted the cycle after the pop.
- In RUN, vid_vs with a non-sof head word → occupancy=0, locked=0, resync_count increments by 1. Repeat 300 times → saturates at 255.
- Assert reset_n mid-frame with a half-full FIFO → all outputs at their reset values asynchronously; the relock sequence then succeeds.
